// File: rtl/fsm_seq_ctrl.sv
// Sequencer that resets, steps and samples an external FSM for up to MAXLEN steps,
// accumulating the step count, the last sampled output code and an XOR checksum.
module fsm_seq_ctrl #(
    parameter int unsigned MAXLEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [3:0]        len,
    input  logic [2:0]        fsm_s,
    output logic              fsm_rst_n,
    output logic              fsm_step,
    output logic              fsm_a,
    output logic              busy,
    output logic              done,
    output logic [3:0]        count,
    output logic [2:0]        last_s,
    output logic [2:0]        checksum
);

    localparam int unsigned CW = 4;
    localparam int unsigned SW = 3;
    localparam logic [CW-1:0] MAXLEN_C = CW'(MAXLEN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_DRIVE  = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MAXLEN-1:0] r_pat;
    logic [MAXLEN-1:0] w_pat_nxt;
    logic [MAXLEN-1:0] w_pat_shift;
    logic [CW-1:0]     r_len;
    logic [CW-1:0]     w_len_nxt;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic [CW-1:0]     w_count_inc;
    logic [SW-1:0]     r_last_s;
    logic [SW-1:0]     w_last_s_nxt;
    logic [SW-1:0]     r_checksum;
    logic [SW-1:0]     w_checksum_nxt;
    logic              r_fsm_rst_n;
    logic              r_fsm_step;
    logic              r_fsm_a;
    logic              r_busy;
    logic              r_done;
    logic              w_fsm_a_nxt;

    // Next-state, datapath and next-output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_pat_nxt      = r_pat;
        w_len_nxt      = r_len;
        w_count_nxt    = r_count;
        w_last_s_nxt   = r_last_s;
        w_checksum_nxt = r_checksum;
        w_count_inc    = r_count + CW'(1);
        w_fsm_a_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt    = S_INIT;
                    w_pat_nxt      = pattern;
                    w_len_nxt      = (len > MAXLEN_C) ? MAXLEN_C : len;
                    w_count_nxt    = '0;
                    w_checksum_nxt = '0;
                end
            end
            S_INIT: begin
                if (abort)
                    w_state_nxt = S_IDLE;
                else if (r_len == '0)
                    w_state_nxt = S_DONE;
                else
                    w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                w_state_nxt = abort ? S_IDLE : S_SAMPLE;
            end
            S_SAMPLE: begin
                // An abort here discards this step's sample entirely
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_last_s_nxt   = fsm_s;
                    w_checksum_nxt = r_checksum ^ fsm_s;
                    w_count_nxt    = w_count_inc;
                    w_state_nxt    = (w_count_inc == r_len) ? S_DONE : S_DRIVE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_pat_shift = w_pat_nxt >> w_count_nxt;
        case (w_state_nxt)
            S_DRIVE:  w_fsm_a_nxt = w_pat_shift[0];
            S_SAMPLE: w_fsm_a_nxt = r_fsm_a;
            default:  w_fsm_a_nxt = 1'b0;
        endcase
    end

    // State, datapath and registered outputs aligned with the state they decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_last_s    <= '0;
            r_checksum  <= '0;
            r_fsm_rst_n <= 1'b0;
            r_fsm_step  <= 1'b0;
            r_fsm_a     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pat       <= w_pat_nxt;
            r_len       <= w_len_nxt;
            r_count     <= w_count_nxt;
            r_last_s    <= w_last_s_nxt;
            r_checksum  <= w_checksum_nxt;
            r_fsm_rst_n <= (w_state_nxt != S_INIT);
            r_fsm_step  <= (w_state_nxt == S_DRIVE);
            r_fsm_a     <= w_fsm_a_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign fsm_rst_n = r_fsm_rst_n;
    assign fsm_step  = r_fsm_step;
    assign fsm_a     = r_fsm_a;
    assign busy      = r_busy;
    assign done      = r_done;
    assign count     = r_count;
    assign last_s    = r_last_s;
    assign checksum  = r_checksum;

endmodule

// File: doc/fsm_seq_ctrl.md
FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

Interface
REQ-001 Parameter: MAXLEN, 8, maximum steps per run; pattern width in bits.
REQ-002 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  run request, sampled only in IDLE.
REQ-005 Port: abort  in  1  terminate the current run.
REQ-006 Port: pattern  in  MAXLEN  input bits for the FSM; step i uses bit i.
REQ-007 Port: len  in  4  number of steps requested.
REQ-008 Port: fsm_s  in  3  output code of the sequenced FSM.
REQ-009 Port: fsm_rst_n  out  1  active-low reset to the sequenced FSM.
REQ-010 Port: fsm_step  out  1  one-cycle clock-enable to the sequenced FSM.
REQ-011 Port: fsm_a  out  1  input bit to the sequenced FSM.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: done  out  1  one-cycle completion pulse.
REQ-014 Port: count  out  4  steps completed in the current or last run.
REQ-015 Port: last_s  out  3  last captured fsm_s.
REQ-016 Port: checksum  out  3  XOR of all fsm_s captured in the run.
REQ-017 Decided: one clock; reset is synchronous and active-high.

Function
REQ-018 The block SHALL be a registered FSM with states IDLE, INIT, DRIVE, SAMPLE and DONE; all outputs SHALL be registered or decoded from state only.
REQ-019 In IDLE with start=1 and abort=0, the block SHALL latch pattern and len, clear count and checksum, and move to INIT.
REQ-020 The latched length SHALL be min(len, MAXLEN).
REQ-021 INIT SHALL last exactly one cycle with fsm_rst_n=0 and fsm_step=0.
REQ-022 From INIT, the block SHALL go to DONE if the latched length is 0; otherwise it SHALL go to DRIVE.
REQ-023 DRIVE SHALL last one cycle with fsm_step=1 and fsm_a=latched pattern[count].
REQ-024 SAMPLE SHALL last one cycle with fsm_step=0 and fsm_a held.
- At the end of SAMPLE: last_s<=fsm_s, checksum<=checksum^fsm_s, count<=count+1.
REQ-025 After SAMPLE, the block SHALL go to DONE if count+1 equals the latched length; otherwise it SHALL go to DRIVE.
REQ-026 Each step SHALL take 2 cycles; a run of N>=1 steps SHALL take 2N+2 cycles from start acceptance to the done pulse, inclusive.
REQ-027 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-028 count, last_s and checksum SHALL hold their values in IDLE until the next accepted start.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 abort=1 in INIT, DRIVE or SAMPLE SHALL force IDLE on the next edge.
- No done pulse; fsm_step=0 from that edge.
- count, last_s and checksum keep their partial values.
REQ-031 abort SHALL take priority over start and over every other transition; abort in IDLE or DONE SHALL have no effect.
REQ-032 fsm_rst_n SHALL be 1 in every state except INIT.
REQ-033 fsm_a SHALL be 0 in IDLE, INIT and DONE.
REQ-034 count arithmetic SHALL be 4-bit unsigned; MAXLEN<=15 SHALL guarantee no overflow.

Reset
REQ-035 reset=1 at a rising edge SHALL force IDLE and set: busy=0, done=0, fsm_step=0, fsm_a=0, fsm_rst_n=0, count=0, last_s=0, checksum=0.
REQ-036 fsm_rst_n SHALL return to 1 on the first edge with reset=0.
REQ-037 reset SHALL override abort and start, including mid-run.

Verification
REQ-038 Run of 4 steps: pattern=0x00, len=4; bench returns fsm_s 3,2,4,0 in successive SAMPLE cycles -> fsm_a=0 throughout, done 10 cycles after start, count=4, last_s=0, checksum=5.
REQ-039 Pattern application: pattern=0x05, len=3 -> fsm_a=1,0,1 in the three DRIVE cycles; fsm_step high in exactly 3 cycles.
REQ-040 Zero and oversize length: len=0 -> INIT then DONE, count=0; len=12 with MAXLEN=8 -> exactly 8 steps, count=8.
REQ-041 Abort: abort asserted in the 2nd SAMPLE of a len=5 run -> IDLE next cycle, no done pulse, count=1, busy=0.
REQ-042 Start while busy: start held high through a len=2 run -> exactly one run, one done pulse, then a new run starts from the IDLE cycle.
REQ-043 Reset mid-run: reset asserted during DRIVE -> all outputs at reset values next cycle, fsm_rst_n=1 the cycle after reset drops.
